// File: rtl/axi4_lite_regfile_if.sv
// AXI4-Lite bus bundle for the register file.
// Valid/ready rule on every channel: a transfer happens on a rising clock edge where
// valid and ready are both 1; once valid is raised, its payload holds until that edge.
interface axi4_lite_regfile_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite subordinate register file: NUM_REGS registers, byte-strobe writes,
// read-only slots mirroring hw_status, SLVERR on out-of-range or read-only writes.
module axi4_lite_regfile #(
   parameter int                      DATA_WIDTH  = 32,
   parameter int                      ADDR_WIDTH  = 32,
   parameter int                      NUM_REGS    = 8,
   parameter logic [NUM_REGS-1:0]     RO_MASK     = '0,
   parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0
) (
   input  logic                           aclk,
   input  logic                           areset,
   axi4_lite_regfile_if.slave             s_axi,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            reg_wr_pulse,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
   output logic                           dbg_wr_state,
   output logic                           dbg_rd_state
);

   localparam int STRB_W   = DATA_WIDTH / 8;
   localparam int OFF_BITS = $clog2(STRB_W);
   localparam int IDX_W    = ADDR_WIDTH - OFF_BITS;
   localparam logic [IDX_W-1:0] NUM_REGS_IDX = IDX_W'(NUM_REGS);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic { W_COLLECT = 1'b0, W_RESP = 1'b1 } w_state_t;
   typedef enum logic { R_IDLE = 1'b0, R_DATA = 1'b1 } r_state_t;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic                  aw_held, w_held;
   logic [IDX_W-1:0]      aw_idx;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]     wstrb_q;
   logic [1:0]            bresp_q;
   logic                  aw_take, w_take, commit, wr_en;
   logic                  aw_in_range, aw_ro;

   logic [IDX_W-1:0]      ar_idx;
   logic                  ar_take;
   logic [DATA_WIDTH-1:0] rd_data_d, rdata_q;
   logic [1:0]            rd_resp_d, rresp_q;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   // Readies/valids are functions of registered state only; the areset term
   // forces them low during the whole reset cycle, including the first one.
   assign s_axi.awready = !areset && (w_state == W_COLLECT) && !aw_held;
   assign s_axi.wready  = !areset && (w_state == W_COLLECT) && !w_held;
   assign s_axi.bvalid  = !areset && (w_state == W_RESP);
   assign s_axi.bresp   = areset ? 2'b00 : bresp_q;
   assign s_axi.arready = !areset && (r_state == R_IDLE);
   assign s_axi.rvalid  = !areset && (r_state == R_DATA);
   assign s_axi.rdata   = areset ? '0 : rdata_q;
   assign s_axi.rresp   = areset ? 2'b00 : rresp_q;

   assign dbg_wr_state = (w_state == W_RESP);
   assign dbg_rd_state = (r_state == R_DATA);

   assign aw_take = s_axi.awready && s_axi.awvalid;
   assign w_take  = s_axi.wready && s_axi.wvalid;
   assign ar_take = s_axi.arready && s_axi.arvalid;

   // ---------------- write path ----------------
   always_comb begin
      aw_in_range = (aw_idx < NUM_REGS_IDX);
      aw_ro       = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (aw_idx == IDX_W'(i)) aw_ro = RO_MASK[i];
      end
   end

   always_comb begin
      w_next = w_state;
      commit = 1'b0;
      case (w_state)
         W_COLLECT: begin
            if (aw_held && w_held && !areset) begin
               commit = 1'b1;
               w_next = W_RESP;
            end
         end
         W_RESP: begin
            if (s_axi.bready) w_next = W_COLLECT;
         end
         default: w_next = W_COLLECT;
      endcase
   end

   assign wr_en = commit && aw_in_range && !aw_ro;

   always_ff @(posedge aclk) begin
      if (areset) w_state <= W_COLLECT;
      else        w_state <= w_next;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         aw_idx  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         bresp_q <= RESP_OKAY;
      end else if (commit) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         bresp_q <= wr_en ? RESP_OKAY : RESP_SLVERR;
      end else begin
         if (aw_take) begin
            aw_held <= 1'b1;
            aw_idx  <= s_axi.awaddr[ADDR_WIDTH-1:OFF_BITS];
         end
         if (w_take) begin
            w_held  <= 1'b1;
            wdata_q <= s_axi.wdata;
            wstrb_q <= s_axi.wstrb;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && (aw_idx == IDX_W'(i))) begin
               for (int k = 0; k < STRB_W; k++) begin
                  if (wstrb_q[k]) regs[i][k*8 +: 8] <= wdata_q[k*8 +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      reg_q        = '0;
      reg_wr_pulse = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
         reg_wr_pulse[i] = wr_en && (aw_idx == IDX_W'(i));
      end
   end

   // ---------------- read path ----------------
   // The register array is sampled before this edge's write lands, so a read
   // racing a commit to the same register returns the old contents.
   always_comb begin
      ar_idx    = s_axi.araddr[ADDR_WIDTH-1:OFF_BITS];
      rd_data_d = '0;
      rd_resp_d = RESP_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ar_idx == IDX_W'(i)) begin
            rd_resp_d = RESP_OKAY;
            rd_data_d = RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
         end
      end
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_take) r_next = R_DATA;
         R_DATA:  if (s_axi.rready) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) r_state <= R_IDLE;
      else        r_state <= r_next;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else if (ar_take) begin
         rdata_q <= rd_data_d;
         rresp_q <= rd_resp_d;
      end
   end

endmodule

// File: doc/axi4_lite_regfile.md
Name: axi4_lite_regfile

Overview:
Parametrised AXI4-Lite subordinate register file. It generalises the existing two-register subordinate to NUM_REGS registers, adds byte-strobe writes, per-register read-only mapping to hardware status inputs, and SLVERR on out-of-range addresses. AW and W are accepted independently. It sits between the AXI4-Lite interconnect and block control/status logic.

Parameters:
DATA_WIDTH, 32, data bus width; 32 or 64 only.
ADDR_WIDTH, 32, address bus width.
NUM_REGS, 8, number of registers; 1..256.
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 means register i is read-only and reads hw_status slice i.
RESET_VALUE, 0, DATA_WIDTH reset value of every writable register.

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read valid
s_axi_rready  in  1  read ready
reg_q  out  NUM_REGS*DATA_WIDTH  register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
reg_wr_pulse  out  NUM_REGS  one-cycle pulse when register i is written
hw_status  in  NUM_REGS*DATA_WIDTH  read values for RO_MASK registers; other slices are ignored

Behaviour:
- Single clock aclk. areset is synchronous and active-high.
- Reset, while areset is high: all ready/valid outputs 0, bresp/rresp 0, rdata 0, reg_wr_pulse 0, writable registers = RESET_VALUE. awready/wready/arready are registered and rise on the first cycle after areset falls.
- Reset mid-transaction: any in-flight AW/W/B/AR/R state is discarded with no response issued, and registers return to RESET_VALUE.
- Address decode: index = addr >> log2(DATA_WIDTH/8). Low byte-offset bits are ignored. index >= NUM_REGS means out of range.
- Write FSM has states W_COLLECT and W_RESP.
  - W_COLLECT: awready=1 until AW is captured; wready=1 until W is captured. AW and W may arrive in either order, in the same cycle, or with any gap. A captured channel deasserts its ready.
  - Commit happens in the cycle both AW and W are held. Then move to W_RESP with bvalid=1 on the next cycle.
  - Commit in range and writable: byte k updated only where wstrb[k]=1. reg_wr_pulse[i]=1 for exactly that cycle, even if wstrb=0. bresp=OKAY(00).
  - Commit out of range: no update, no pulse, bresp=SLVERR(10).
  - Commit to a RO_MASK register: no update, no pulse, bresp=SLVERR(10).
  - W_RESP: bvalid holds with bresp stable until bready=1. Then go to W_COLLECT, with awready/wready=1 on the next cycle.
  - Throughput: one write per 3 cycles minimum when bready is tied high.
- Read FSM has states R_IDLE and R_DATA.
  - R_IDLE: arready=1. On AR handshake, rdata/rresp are registered and the FSM enters R_DATA with rvalid=1 the next cycle (latency 1).
  - R_DATA: arready=0; rdata/rresp hold stable until rready=1, then return to R_IDLE.
  - Data sources: writable register returns its value; RO register returns hw_status sampled at the AR handshake; out of range returns rdata=0, rresp=SLVERR.
- Simultaneous read and write commit to the same register in one cycle: the read returns the pre-write value.
- The read and write paths are fully independent and may be active concurrently.
- reg_q reflects updates on the cycle after commit.

Test Plan:
- Reset value: NUM_REGS=8, RESET_VALUE=0, release areset. Read 0x00 and 0x1C -> 0x00000000, OKAY. Then write 0x04 = 0xDEADBEEF and read back -> 0xDEADBEEF; reg_wr_pulse[1] high for one cycle.
- Strobes: write 0x08 = 0xFFFFFFFF with wstrb=1111, then 0x12345678 with wstrb=0101 -> read 0xFF34FF78. Then wstrb=0000 -> value unchanged, pulse still asserted.
- Channel ordering: W sent 5 cycles before AW, then AW 3 cycles before W, then both in the same cycle. Each case -> exactly one bvalid with OKAY and the correct data stored.
- Errors and RO: RO_MASK=8'h04, hw_status slice 2 = 0xCAFEF00D. Read 0x08 -> 0xCAFEF00D, OKAY. Write 0x08 -> SLVERR, no pulse. Read 0x20 -> 0x0, SLVERR. Write 0x20 -> SLVERR.
- Backpressure: hold bready=0 and rready=0 for 10 cycles -> bvalid/rvalid and data stay stable, and awready/wready/arready stay 0 on their busy channel.
- Mid-transaction reset: assert areset for 1 cycle between AW capture and W capture -> no bvalid issued. Read 0x04 afterwards -> 0x0.
